// File: rtl/bch_corr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : bch_corr_scheduler
// Brief    : Frame-level controller for the p32 BCH correction engine
//            (Euclidean + Chien, t=8, GF(2^13)). Ping-pong buffers syndrome
//            sets, sequences engine reset/start/syndrome feed, waits out the
//            fixed decode window, then streams captured error addresses.
// Revision : 1.0 - initial release
// ============================================================================
module bch_corr_scheduler #(
    parameter int NSYND   = 16,
    parameter int AW      = 13,
    parameter int T       = 8,
    parameter int WINDOW  = 600,
    parameter int RST_CYC = 2
) (
    input  logic          clk,
    input  logic          reset,
    // syndrome stage
    input  logic          synd_valid,
    input  logic [AW-1:0] synd_in,
    output logic          synd_ready,
    // correction engine
    output logic          corr_rstn,
    output logic          corr_start,
    output logic [AW-1:0] corr_gsynd,
    input  logic [3:0]    corr_serr,
    input  logic [AW-1:0] corr_aadd1,
    input  logic [AW-1:0] corr_aadd2,
    input  logic [AW-1:0] corr_aadd3,
    input  logic [AW-1:0] corr_aadd4,
    input  logic [AW-1:0] corr_aadd5,
    input  logic [AW-1:0] corr_aadd6,
    input  logic [AW-1:0] corr_aadd7,
    input  logic [AW-1:0] corr_aadd8,
    // bit-flip stage
    output logic          err_valid,
    output logic [AW-1:0] err_addr,
    output logic          err_last,
    input  logic          err_ready,
    // frame status
    output logic          frame_done,
    output logic [3:0]    frame_nerr,
    output logic          frame_fail
);

    localparam int SW   = (NSYND > 1)   ? $clog2(NSYND)   : 1;
    localparam int RW   = (WINDOW > 1)  ? $clog2(WINDOW)  : 1;
    localparam int KW   = (T > 1)       ? $clog2(T)       : 1;
    localparam int RSTW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    localparam logic [SW-1:0]   c_wcnt_last = SW'(NSYND - 1);
    localparam logic [RW-1:0]   c_run_last  = RW'(WINDOW - 1);
    localparam logic [RW-1:0]   c_nsynd_run = RW'(NSYND);
    localparam logic [RSTW-1:0] c_rst_last  = RSTW'(RST_CYC - 1);
    localparam logic [3:0]      c_t_max     = 4'(T);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENG_RST = 3'd1,
        S_RUN     = 3'd2,
        S_OUT     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [AW-1:0]   r_bank [2][NSYND];
    logic [1:0]      r_full;
    logic            r_fptr;
    logic            r_eptr;
    logic [SW-1:0]   r_wcnt;

    state_t          r_state;
    logic [RSTW-1:0] r_rst_cnt;
    logic [RW-1:0]   r_run_cnt;
    logic [KW-1:0]   r_k;
    logic [3:0]      r_last_k;
    logic [3:0]      r_nerr;
    logic [AW-1:0]   r_addr [T];

    logic            w_accept;
    logic            w_fill_last;
    logic            w_release;
    logic [RW-1:0]   w_run_nx;
    logic [KW-1:0]   w_k_nx;
    logic [AW-1:0]   w_gs_nx;
    logic [AW-1:0]   w_aadd [T];

    // Fill bank is writable whenever it is not holding a complete set.
    assign synd_ready  = ~reset & ~r_full[r_fptr];
    assign w_accept    = synd_valid & synd_ready;
    assign w_fill_last = w_accept & (r_wcnt == c_wcnt_last);

    // The engine bank is handed back on the last cycle of the decode window.
    assign w_release   = (r_state == S_RUN) && (r_run_cnt == c_run_last);

    assign w_run_nx    = r_run_cnt + 1'b1;
    assign w_k_nx      = r_k + 1'b1;

    assign w_aadd[0]   = corr_aadd1;
    assign w_aadd[1]   = corr_aadd2;
    assign w_aadd[2]   = corr_aadd3;
    assign w_aadd[3]   = corr_aadd4;
    assign w_aadd[4]   = corr_aadd5;
    assign w_aadd[5]   = corr_aadd6;
    assign w_aadd[6]   = corr_aadd7;
    assign w_aadd[7]   = corr_aadd8;

    // Syndrome word the engine must see in the following run cycle.
    always_comb begin
        w_gs_nx = '0;
        if (w_run_nx < c_nsynd_run) begin
            w_gs_nx = r_bank[r_eptr][w_run_nx[SW-1:0]];
        end
    end

    // Syndrome word storage; contents are only meaningful while marked full.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_bank[r_fptr][r_wcnt] <= synd_in;
        end
    end

    // Fill-side word counter and bank pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wcnt <= '0;
            r_fptr <= 1'b0;
        end else if (w_accept) begin
            r_wcnt <= w_fill_last ? '0 : r_wcnt + 1'b1;
            if (w_fill_last) begin
                r_fptr <= ~r_fptr;
            end
        end
    end

    // Bank full flags: set by the fill side, cleared by the engine side.
    // Fill and engine banks never coincide while both act, so no conflict.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_fill_last && (r_fptr == 1'(b))) begin
                    r_full[b] <= 1'b1;
                end else if (w_release && (r_eptr == 1'(b))) begin
                    r_full[b] <= 1'b0;
                end
            end
        end
    end

    // Frame sequencer with registered engine, address-stream and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_eptr     <= 1'b0;
            r_rst_cnt  <= '0;
            r_run_cnt  <= '0;
            r_k        <= '0;
            r_last_k   <= '0;
            r_nerr     <= '0;
            for (int i = 0; i < T; i++) begin
                r_addr[i] <= '0;
            end
            corr_rstn  <= 1'b0;
            corr_start <= 1'b0;
            corr_gsynd <= '0;
            err_valid  <= 1'b0;
            err_addr   <= '0;
            err_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_nerr <= '0;
            frame_fail <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    corr_rstn  <= 1'b0;
                    corr_start <= 1'b0;
                    if (r_full[r_eptr]) begin
                        r_rst_cnt <= '0;
                        r_state   <= S_ENG_RST;
                    end
                end

                S_ENG_RST: begin
                    if (r_rst_cnt == c_rst_last) begin
                        // Word 0 is presented in the first run cycle.
                        r_state    <= S_RUN;
                        r_run_cnt  <= '0;
                        corr_rstn  <= 1'b1;
                        corr_start <= 1'b1;
                        corr_gsynd <= r_bank[r_eptr][0];
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end

                S_RUN: begin
                    if (w_release) begin
                        r_nerr <= corr_serr;
                        for (int i = 0; i < T; i++) begin
                            r_addr[i] <= w_aadd[i];
                        end
                        r_eptr     <= ~r_eptr;
                        r_run_cnt  <= '0;
                        corr_start <= 1'b0;
                        corr_rstn  <= 1'b0;
                        corr_gsynd <= '0;
                        if ((corr_serr != 4'd0) && (corr_serr <= c_t_max)) begin
                            r_state   <= S_OUT;
                            r_k       <= '0;
                            r_last_k  <= corr_serr - 4'd1;
                            err_valid <= 1'b1;
                            err_addr  <= w_aadd[0];
                            err_last  <= (corr_serr == 4'd1);
                        end else begin
                            // Zero errors or uncorrectable: no address beats.
                            r_state    <= S_DONE;
                            frame_done <= 1'b1;
                            frame_nerr <= corr_serr;
                            frame_fail <= (corr_serr > c_t_max);
                        end
                    end else begin
                        r_run_cnt  <= w_run_nx;
                        corr_gsynd <= w_gs_nx;
                    end
                end

                S_OUT: begin
                    // Beat fields only move on a completed handshake.
                    if (err_valid && err_ready) begin
                        if (err_last) begin
                            err_valid  <= 1'b0;
                            err_last   <= 1'b0;
                            err_addr   <= '0;
                            r_state    <= S_DONE;
                            frame_done <= 1'b1;
                            frame_nerr <= r_nerr;
                            frame_fail <= 1'b0;
                        end else begin
                            r_k      <= w_k_nx;
                            err_addr <= r_addr[w_k_nx];
                            err_last <= (4'(w_k_nx) == r_last_k);
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bch_corr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_corr_scheduler
// Brief    : Self-checking bench for bch_corr_scheduler. Frame vectors from a
//            table drive a behavioural engine model and a scoreboard of
//            expected address beats and frame status.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bch_corr_scheduler;

    localparam int AW      = 13;
    localparam int NSYND   = 16;
    localparam int WINDOW  = 600;
    localparam int RST_CYC = 2;
    localparam int PERIOD0 = 1 + RST_CYC + WINDOW + 1;

    typedef struct {
        logic [AW-1:0]        base;
        logic [3:0]           serr;
        logic [7:0][AW-1:0]   addr;
        int                   stall;
        logic [3:0]           exp_nerr;
        bit                   exp_fail;
        int                   exp_beats;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        bit            last;
    } beat_t;

    typedef struct {
        logic [3:0] nerr;
        bit         fail;
        int         beats;
    } done_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          synd_valid;
    logic [AW-1:0] synd_in;
    logic          synd_ready;
    logic          corr_rstn;
    logic          corr_start;
    logic [AW-1:0] corr_gsynd;
    logic [3:0]    corr_serr;
    logic [AW-1:0] corr_aadd1, corr_aadd2, corr_aadd3, corr_aadd4;
    logic [AW-1:0] corr_aadd5, corr_aadd6, corr_aadd7, corr_aadd8;
    logic          err_valid;
    logic [AW-1:0] err_addr;
    logic          err_last;
    logic          err_ready;
    logic          frame_done;
    logic [3:0]    frame_nerr;
    logic          frame_fail;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_done   = 0;
    int done_cyc = 0;
    int eng_rc   = 0;
    int stall_mode = 0;

    vec_t  eng_q  [$];
    beat_t beat_q [$];
    done_t done_q [$];

    bch_corr_scheduler #(
        .NSYND(NSYND), .AW(AW), .T(8), .WINDOW(WINDOW), .RST_CYC(RST_CYC)
    ) dut (
        .clk(clk), .reset(reset),
        .synd_valid(synd_valid), .synd_in(synd_in), .synd_ready(synd_ready),
        .corr_rstn(corr_rstn), .corr_start(corr_start), .corr_gsynd(corr_gsynd),
        .corr_serr(corr_serr),
        .corr_aadd1(corr_aadd1), .corr_aadd2(corr_aadd2), .corr_aadd3(corr_aadd3),
        .corr_aadd4(corr_aadd4), .corr_aadd5(corr_aadd5), .corr_aadd6(corr_aadd6),
        .corr_aadd7(corr_aadd7), .corr_aadd8(corr_aadd8),
        .err_valid(err_valid), .err_addr(err_addr), .err_last(err_last),
        .err_ready(err_ready),
        .frame_done(frame_done), .frame_nerr(frame_nerr), .frame_fail(frame_fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s: bound expired or unexpected event (cycle %0d)", nm, cyc);
    endtask

    function automatic vec_t mk(input logic [AW-1:0] base, input logic [3:0] serr,
                                input int stall, input logic [3:0] en, input bit ef,
                                input int eb);
        vec_t v;
        v.base = base;
        v.serr = serr;
        for (int j = 0; j < 8; j++) v.addr[j] = AW'(base + 16'h0040 * j + 3);
        v.stall     = stall;
        v.exp_nerr  = en;
        v.exp_fail  = ef;
        v.exp_beats = eb;
        return v;
    endfunction

    task automatic push_frame(input vec_t v);
        beat_t b;
        done_t d;
        eng_q.push_back(v);
        for (int j = 0; j < v.exp_beats; j++) begin
            b.addr = v.addr[j];
            b.last = (j == v.exp_beats - 1);
            beat_q.push_back(b);
        end
        d.nerr  = v.exp_nerr;
        d.fail  = v.exp_fail;
        d.beats = v.exp_beats;
        done_q.push_back(d);
    endtask

    // Called in the posedge+1 phase; returns in the same phase.
    task automatic send_word(input logic [AW-1:0] w, output int acc);
        int guard;
        bit got;
        guard = 0;
        got   = 0;
        acc   = -1;
        synd_valid = 1'b1;
        synd_in    = w;
        while (!got && guard < 4000) begin
            @(negedge clk);
            if (synd_ready) begin
                got = 1;
                acc = cyc;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        synd_valid = 1'b0;
        synd_in    = '0;
        if (!got) fail_now("synd_accept_timeout");
    endtask

    task automatic send_frame(input logic [AW-1:0] base, output int first, output int last);
        int acc;
        first = -1;
        last  = -1;
        for (int i = 0; i < NSYND; i++) begin
            send_word(AW'(base + i), acc);
            if (i == 0) first = acc;
            last = acc;
        end
    endtask

    task automatic wait_done(input int target, input int bound);
        int n;
        n = 0;
        while (n_done < target && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n_done < target) fail_now("frame_done_timeout");
    endtask

    // Downstream ready pattern.
    initial begin
        err_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (stall_mode)
                0:       err_ready = 1'b1;
                1:       err_ready = ~err_ready;
                default: err_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Behavioural correction engine: checks the syndrome feed and returns
    // the error count/addresses of the frame it is decoding.
    initial begin : engine_model
        vec_t cur;
        bit   in_run;
        bit   gs_ok;
        logic [AW-1:0] exp_gs;
        in_run = 0;
        gs_ok  = 1;
        cur    = mk('0, 4'd0, 0, 4'd0, 1'b0, 0);
        corr_serr = '0;
        {corr_aadd1, corr_aadd2, corr_aadd3, corr_aadd4} = '0;
        {corr_aadd5, corr_aadd6, corr_aadd7, corr_aadd8} = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_run = 0;
                eng_rc = 0;
            end else if (corr_start) begin
                if (!in_run) begin
                    in_run = 1;
                    eng_rc = 0;
                    gs_ok  = 1;
                    if (eng_q.size() == 0) begin
                        fail_now("engine_unexpected_start");
                    end else begin
                        cur = eng_q.pop_front();
                        corr_serr  = cur.serr;
                        corr_aadd1 = cur.addr[0]; corr_aadd2 = cur.addr[1];
                        corr_aadd3 = cur.addr[2]; corr_aadd4 = cur.addr[3];
                        corr_aadd5 = cur.addr[4]; corr_aadd6 = cur.addr[5];
                        corr_aadd7 = cur.addr[6]; corr_aadd8 = cur.addr[7];
                    end
                end
                exp_gs = (eng_rc < NSYND) ? AW'(cur.base + eng_rc) : '0;
                if (corr_gsynd !== exp_gs || corr_rstn !== 1'b1) gs_ok = 0;
                eng_rc++;
            end else if (in_run) begin
                in_run = 0;
                check("run_gsynd_seq", 32'(gs_ok), 32'd1);
                check("run_length", eng_rc, WINDOW);
            end
        end
    end

    // Output monitor: address beats, hold-while-stalled, frame status.
    initial begin : out_monitor
        bit   prev_stall;
        logic [AW-1:0] prev_addr;
        bit   prev_last;
        int   beats_seen;
        beat_t b;
        done_t d;
        prev_stall = 0;
        prev_addr  = '0;
        prev_last  = 0;
        beats_seen = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 0;
                beats_seen = 0;
            end else begin
                if (prev_stall) begin
                    check("beat_hold_valid", 32'(err_valid), 32'd1);
                    check("beat_hold_addr", 32'(err_addr), 32'(prev_addr));
                    check("beat_hold_last", 32'(err_last), 32'(prev_last));
                end
                prev_stall = err_valid && !err_ready;
                prev_addr  = err_addr;
                prev_last  = err_last;
                if (err_valid && err_ready) begin
                    if (beat_q.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        b = beat_q.pop_front();
                        check("beat_addr", 32'(err_addr), 32'(b.addr));
                        check("beat_last", 32'(err_last), 32'(b.last));
                    end
                    beats_seen++;
                end
                if (frame_done) begin
                    n_done++;
                    done_cyc = cyc;
                    if (done_q.size() == 0) begin
                        fail_now("unexpected_frame_done");
                    end else begin
                        d = done_q.pop_front();
                        check("frame_nerr", 32'(frame_nerr), 32'(d.nerr));
                        check("frame_fail", 32'(frame_fail), 32'(d.fail));
                        check("frame_beats", beats_seen, d.beats);
                    end
                    beats_seen = 0;
                end
            end
        end
    end

    initial begin : main
        vec_t vecs [7];
        vec_t tri3 [3];
        int first_a, last_a, first_b, last_b, first_c, last_c, nd0, n;

        reset      = 1'b1;
        synd_valid = 1'b0;
        synd_in    = '0;

        vecs[0] = mk(13'h0001, 4'd0,  0, 4'd0,  1'b0, 0);
        vecs[1] = mk(13'h0100, 4'd3,  0, 4'd3,  1'b0, 3);
        vecs[1].addr[0] = 13'h1007;
        vecs[1].addr[1] = 13'h0A3E;
        vecs[1].addr[2] = 13'h0005;
        vecs[2] = vecs[1];
        vecs[2].stall = 1;
        vecs[3] = mk(13'h0200, 4'd9,  0, 4'd9,  1'b1, 0);
        vecs[4] = mk(13'h0300, 4'd8,  2, 4'd8,  1'b0, 8);
        vecs[5] = mk(13'h0400, 4'd1,  0, 4'd1,  1'b0, 1);
        vecs[6] = mk(13'h0480, 4'd15, 0, 4'd15, 1'b1, 0);
        tri3[0] = mk(13'h0500, 4'd2,  0, 4'd2,  1'b0, 2);
        tri3[1] = mk(13'h0600, 4'd0,  0, 4'd0,  1'b0, 0);
        tri3[2] = mk(13'h0700, 4'd9,  0, 4'd9,  1'b1, 0);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_corr_rstn",  32'(corr_rstn),  32'd0);
        check("rst_corr_start", 32'(corr_start), 32'd0);
        check("rst_corr_gsynd", 32'(corr_gsynd), 32'd0);
        check("rst_err_valid",  32'(err_valid),  32'd0);
        check("rst_err_last",   32'(err_last),   32'd0);
        check("rst_err_addr",   32'(err_addr),   32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_nerr", 32'(frame_nerr), 32'd0);
        check("rst_frame_fail", 32'(frame_fail), 32'd0);
        check("rst_synd_ready", 32'(synd_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(synd_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset in the middle of a decode window
        push_frame(vecs[1]);
        send_frame(vecs[1].base, first_a, last_a);
        n = 0;
        while (eng_rc < 100 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (eng_rc < 100) fail_now("run_start_timeout");
        reset = 1'b1;
        eng_q.delete();
        beat_q.delete();
        done_q.delete();
        @(negedge clk);
        check("abort_synd_ready", 32'(synd_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_corr_rstn",  32'(corr_rstn),  32'd0);
        check("abort_corr_start", 32'(corr_start), 32'd0);
        check("abort_gsynd",      32'(corr_gsynd), 32'd0);
        check("abort_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        nd0 = n_done;
        repeat (700) @(posedge clk);
        #1;
        check("abort_no_done", n_done, nd0);

        // Table-driven single frames
        for (int i = 0; i < 7; i++) begin
            stall_mode = vecs[i].stall;
            nd0 = n_done;
            push_frame(vecs[i]);
            send_frame(vecs[i].base, first_a, last_a);
            wait_done(nd0 + 1, 2000);
            if (i == 0) check("done_latency", done_cyc - last_a, PERIOD0);
        end
        stall_mode = 0;

        // Three frames back to back: both banks fill, third waits for release
        nd0 = n_done;
        for (int f = 0; f < 3; f++) push_frame(tri3[f]);
        send_frame(tri3[0].base, first_a, last_a);
        send_frame(tri3[1].base, first_b, last_b);
        @(negedge clk);
        check("ready_low_both_full", 32'(synd_ready), 32'd0);
        @(posedge clk);
        #1;
        send_frame(tri3[2].base, first_c, last_c);
        check("ready_rise_at_release", first_c - last_a, PERIOD0);
        wait_done(nd0 + 3, 4000);

        check("beat_q_drained", beat_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        check("eng_q_drained",  eng_q.size(),  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
